// File: rtl/rps_pkg.sv
// Shared move/result encodings, FSM state type and rule helpers for the RPS referee.
package rps_pkg;

    localparam logic [2:0] PAPER    = 3'b100;
    localparam logic [2:0] ROCK     = 3'b010;
    localparam logic [2:0] SCISSORS = 3'b001;

    localparam logic [1:0] RES_INVALID = 2'b00;
    localparam logic [1:0] RES_A_WIN   = 2'b01;
    localparam logic [1:0] RES_B_WIN   = 2'b10;
    localparam logic [1:0] RES_TIE     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_onehot3(input logic [2:0] m);
        return (m == PAPER) || (m == ROCK) || (m == SCISSORS);
    endfunction

    // Raw AND-OR rule terms: does move x beat move y (bits taken as-is)
    function automatic logic beats(input logic [2:0] x, input logic [2:0] y);
        return (x[2] & y[1]) | (x[1] & y[0]) | (x[0] & y[2]);
    endfunction

endpackage

// File: rtl/rps_round_judge.sv
// Combinational round judge. Define RPS_ONEHOT_CHECK_EN to flag non-one-hot moves
// as invalid (00); otherwise conflicting or absent rule terms judge as a tie.
module rps_round_judge
    import rps_pkg::*;
(
    input  logic [2:0] inA,
    input  logic [2:0] inB,
    output logic [1:0] result
);

    logic a_fire_s;
    logic b_fire_s;

    // Decide the round from the rule terms of both players
    always_comb begin
        a_fire_s = beats(inA, inB);
        b_fire_s = beats(inB, inA);
        result   = RES_TIE;
`ifdef RPS_ONEHOT_CHECK_EN
        if (!is_onehot3(inA) || !is_onehot3(inB)) begin
            result = RES_INVALID;
        end else if (a_fire_s && !b_fire_s) begin
            result = RES_A_WIN;
        end else if (b_fire_s && !a_fire_s) begin
            result = RES_B_WIN;
        end else begin
            result = RES_TIE;
        end
`else
        if (a_fire_s && !b_fire_s) begin
            result = RES_A_WIN;
        end else if (b_fire_s && !a_fire_s) begin
            result = RES_B_WIN;
        end else begin
            result = RES_TIE;
        end
`endif
    end

endmodule

// File: rtl/rps_match_referee.sv
// Rock-paper-scissors match referee: accepts move pairs, keeps score, declares a winner.
// Optional macro RPS_ONEHOT_CHECK_EN (see rps_round_judge) enables invalid-move detection.
module rps_match_referee
    import rps_pkg::*;
#(
    parameter int WIN_TARGET = 3,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [2:0]         inA,
    input  logic [2:0]         inB,
    output logic               result_valid,
    output logic [1:0]         result,
    output logic [SCORE_W-1:0] scoreA,
    output logic [SCORE_W-1:0] scoreB,
    output logic [SCORE_W-1:0] round_cnt,
    output logic               match_done,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] TARGET  = SCORE_W'(WIN_TARGET);
    localparam logic [SCORE_W-1:0] CNT_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] ONE     = SCORE_W'(1);

    state_t             state_r;
    logic               ready_r;
    logic               result_valid_r;
    logic [1:0]         result_r;
    logic [SCORE_W-1:0] score_a_r;
    logic [SCORE_W-1:0] score_b_r;
    logic [SCORE_W-1:0] round_cnt_r;
    logic               match_done_r;
    logic               winner_r;

    logic [1:0]         judge_s;
    logic [SCORE_W-1:0] inc_a_s;
    logic [SCORE_W-1:0] inc_b_s;
    logic [SCORE_W-1:0] round_next_s;

    rps_round_judge u_judge (
        .inA    (inA),
        .inB    (inB),
        .result (judge_s)
    );

    // Next-value arithmetic for scores and the saturating round counter
    always_comb begin
        inc_a_s = score_a_r + ONE;
        inc_b_s = score_b_r + ONE;
        if (round_cnt_r == CNT_MAX) begin
            round_next_s = CNT_MAX;
        end else begin
            round_next_s = round_cnt_r + ONE;
        end
    end

    // Match FSM with all outputs registered; start overrides any pending move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            ready_r        <= 1'b0;
            result_valid_r <= 1'b0;
            result_r       <= 2'b00;
            score_a_r      <= '0;
            score_b_r      <= '0;
            round_cnt_r    <= '0;
            match_done_r   <= 1'b0;
            winner_r       <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            if (start) begin
                state_r      <= ST_PLAY;
                ready_r      <= 1'b1;
                result_r     <= 2'b00;
                score_a_r    <= '0;
                score_b_r    <= '0;
                round_cnt_r  <= '0;
                match_done_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end
                    ST_PLAY: begin
                        if (move_valid) begin
                            result_valid_r <= 1'b1;
                            result_r       <= judge_s;
                            round_cnt_r    <= round_next_s;
                            if (judge_s == RES_A_WIN) begin
                                score_a_r <= inc_a_s;
                                if (inc_a_s == TARGET) begin
                                    state_r      <= ST_DONE;
                                    ready_r      <= 1'b0;
                                    match_done_r <= 1'b1;
                                    winner_r     <= 1'b0;
                                end
                            end else if (judge_s == RES_B_WIN) begin
                                score_b_r <= inc_b_s;
                                if (inc_b_s == TARGET) begin
                                    state_r      <= ST_DONE;
                                    ready_r      <= 1'b0;
                                    match_done_r <= 1'b1;
                                    winner_r     <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                        ready_r <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign move_ready   = ready_r;
    assign result_valid = result_valid_r;
    assign result       = result_r;
    assign scoreA       = score_a_r;
    assign scoreB       = score_b_r;
    assign round_cnt    = round_cnt_r;
    assign match_done   = match_done_r;
    assign winner       = winner_r;

endmodule

// File: tb/tb_rps_match_referee.sv
// Self-checking bench for rps_match_referee: directed steps plus randomized play against a match model.
module tb_rps_match_referee;

    localparam logic [2:0] P = 3'b100;
    localparam logic [2:0] R = 3'b010;
    localparam logic [2:0] S = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, move_valid, move_ready, result_valid, match_done, winner;
    logic [2:0] inA, inB;
    logic [1:0] result;
    logic [3:0] scoreA, scoreB, round_cnt;

    logic       start2, mv2, ready2, rv2, done2, win2;
    logic [2:0] a2, b2;
    logic [1:0] res2;
    logic [1:0] sa2, sb2, rc2;

    int checks   = 0;
    int failures = 0;

    // match model state
    bit       m_play, m_done, m_win, m_rv;
    int       m_sa, m_sb, m_rc;
    bit [1:0] m_res;

    rps_match_referee #(.WIN_TARGET(3), .SCORE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
        .move_ready(move_ready), .inA(inA), .inB(inB), .result_valid(result_valid),
        .result(result), .scoreA(scoreA), .scoreB(scoreB), .round_cnt(round_cnt),
        .match_done(match_done), .winner(winner)
    );

    rps_match_referee #(.WIN_TARGET(3), .SCORE_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .move_valid(mv2),
        .move_ready(ready2), .inA(a2), .inB(b2), .result_valid(rv2),
        .result(res2), .scoreA(sa2), .scoreB(sb2), .round_cnt(rc2),
        .match_done(done2), .winner(win2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference judge: moves indexed Paper=0, Rock=1, Scissors=2; x beats y when (y-x) mod 3 == 1
    function automatic bit [1:0] ref_judge(input logic [2:0] a, input logic [2:0] b);
        bit af = 0;
        bit bf = 0;
`ifdef RPS_ONEHOT_CHECK_EN
        if ($countones(a) != 1 || $countones(b) != 1) return 2'b00;
`endif
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (a[2-i] && b[2-j]) begin
                    if ((j - i + 3) % 3 == 1) af = 1;
                    if ((i - j + 3) % 3 == 1) bf = 1;
                end
            end
        end
        if (af && !bf) return 2'b01;
        if (bf && !af) return 2'b10;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_play = 0; m_done = 0; m_win = 0; m_rv = 0;
        m_sa = 0; m_sb = 0; m_rc = 0; m_res = 2'b00;
    endtask

    task automatic model_edge(input bit st, input bit mv, input logic [2:0] a, input logic [2:0] b);
        m_rv = 0;
        if (st) begin
            m_play = 1; m_done = 0; m_sa = 0; m_sb = 0; m_rc = 0; m_res = 2'b00;
        end else if (m_play && mv) begin
            m_res = ref_judge(a, b);
            m_rv  = 1;
            m_rc  = (m_rc < 15) ? m_rc + 1 : 15;
            if (m_res == 2'b01) m_sa++;
            if (m_res == 2'b10) m_sb++;
            if (m_sa == 3 || m_sb == 3) begin
                m_done = 1; m_play = 0; m_win = (m_sb == 3);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"}, move_ready, m_play);
        chk({tag, ".rv"}, result_valid, m_rv);
        chk({tag, ".result"}, result, m_res);
        chk({tag, ".scoreA"}, scoreA, m_sa);
        chk({tag, ".scoreB"}, scoreB, m_sb);
        chk({tag, ".round"}, round_cnt, m_rc);
        chk({tag, ".done"}, match_done, m_done);
        chk({tag, ".winner"}, winner, m_win);
    endtask

    // One clock: drive at negedge, let the edge happen, check at the next negedge
    task automatic step(input string tag, input bit st, input bit mv, input logic [2:0] a, input logic [2:0] b);
        start = st; move_valid = mv; inA = a; inB = b;
        @(posedge clk);
        model_edge(st, mv, a, b);
        @(negedge clk);
        start = 1'b0; move_valid = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; inA = 3'b000; inB = 3'b000;
        start2 = 1'b0; mv2 = 1'b0; a2 = 3'b000; b2 = 3'b000;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // no start yet: moves ignored in IDLE
        step("idle_move", 0, 1, P, R);
        step("start", 1, 0, 3'b000, 3'b000);
        step("a_win1", 0, 1, P, R);
        chk("a_win1.scoreA_const", scoreA, 1);
        step("a_win2", 0, 1, P, R);
        chk("a_win2.scoreA_const", scoreA, 2);
        step("a_win3", 0, 1, P, R);
        chk("a_win3.scoreA_const", scoreA, 3);
        chk("a_win3.done_const", match_done, 1);
        chk("a_win3.winner_const", winner, 0);
        chk("a_win3.result_const", result, 1);

        // DONE ignores moves, then start resumes play
        step("done_move", 0, 1, R, P);
        chk("done_move.rv_const", result_valid, 0);
        step("done_idle", 0, 0, 3'b000, 3'b000);
        step("restart", 1, 0, 3'b000, 3'b000);
        chk("restart.scoreA_const", scoreA, 0);
        chk("restart.ready_const", move_ready, 1);

        step("tie", 0, 1, R, R);
        chk("tie.result_const", result, 3);
        chk("tie.round_const", round_cnt, 1);

        step("bad_pair", 0, 1, 3'b110, 3'b001);
`ifdef RPS_ONEHOT_CHECK_EN
        chk("bad_pair.result_const", result, 0);
`else
        chk("bad_pair.result_const", result, 3);
`endif
        chk("bad_pair.scoreA_const", scoreA, 0);

        step("b_win", 0, 1, S, R);
        step("start_and_move", 1, 1, P, R);
        chk("start_and_move.rv_const", result_valid, 0);
        chk("start_and_move.scoreA_const", scoreA, 0);

        // asynchronous reset mid-match, away from any clock edge
        step("pre_rst", 0, 1, P, S);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst_move", 0, 1, P, R);

        // round counter saturation on the narrow instance
        start2 = 1'b1;
        @(posedge clk); @(negedge clk);
        start2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            mv2 = 1'b1; a2 = R; b2 = R;
            @(posedge clk); @(negedge clk);
            mv2 = 1'b0;
            chk("sat.round", rc2, (i < 3) ? i : 3);
            chk("sat.result", res2, 3);
            chk("sat.ready", ready2, 1);
        end

        // randomized play against the model
        step("rnd_start", 1, 0, 3'b000, 3'b000);
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ra, rb;
            bit rs, rm;
            rs = ($urandom_range(0, 29) == 0);
            rm = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) ra = 3'($urandom); else ra = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) rb = 3'($urandom); else rb = 3'b001 << $urandom_range(0, 2);
            if (m_done && $urandom_range(0, 3) == 0) rs = 1;
            step("rnd", rs, rm, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
